// File: rtl/rot_pkg.sv
// Shared definitions for the ring-oscillator PUF evaluator: FSM state
// encoding, drain length and the phase timer width.
package rot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Two cycles are enough to empty the two-flop synchronizer before the
  // counts are compared.
  localparam int DRAIN_CYC = 2;

  // Phase timer must hold WINDOW-1 for WINDOW up to 2^20.
  localparam int TMR_W = 21;

endpackage

// File: rtl/ro_puf_eval_counter.sv
// ro_edge_counter: synchronizes one ring-oscillator output into the clk
// domain, detects rising edges and counts them with saturation.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic ro_p0;
  logic ro_p1;
  logic ro_p2;
  logic rise;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Two-flop synchronizer (p0, p1) plus one history flop (p2) for the edge detector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ro_p0 <= 1'b0;
      ro_p1 <= 1'b0;
      ro_p2 <= 1'b0;
    end else begin
      ro_p0 <= ro;
      ro_p1 <= ro_p0;
      ro_p2 <= ro_p1;
    end
  end

  assign rise = ro_p1 & ~ro_p2;

  // Edge counter: cleared on evaluation start, counts only while enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && rise) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/ro_puf_eval.sv
// ro_puf_eval: runs one ring-oscillator PUF evaluation per start request.
// Both oscillators are enabled, allowed to settle, their rising edges are
// counted over a fixed window, the synchronizers are drained, and the
// response bit is count_a > count_b.
// Optional feature: define RO_PUF_MARGIN_EN to add the 'unreliable' output,
// flagging results whose counts differ by less than MARGIN.
module ro_puf_eval
  import rot_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 8,
  parameter int MARGIN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
`ifdef RO_PUF_MARGIN_EN
  ,
  output logic             unreliable
`endif
);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(DRAIN_CYC - 1);

  // Reject parameter values outside the supported ranges at elaboration.
  if (SETTLE < 1 || SETTLE > 255 || WINDOW < 1 || WINDOW > 2**20 ||
      MARGIN < 0 || CNT_W < 1 || CNT_W > 31) begin : g_param_check
    $error("ro_puf_eval: parameter out of range");
  end

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic             clr;
  logic             cnt_en;
  logic             latch;

  // State register and phase timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next-state logic: each timed phase loads its length minus one on entry
  // and leaves when the timer reaches zero.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    clr       = 1'b0;
    cnt_en    = 1'b0;
    latch     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
          tmr_nxt   = SETTLE_LD;
          clr       = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr == '0) begin
          state_nxt = ST_COUNT;
          tmr_nxt   = WINDOW_LD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      ST_COUNT: begin
        cnt_en = 1'b1;
        if (tmr == '0) begin
          state_nxt = ST_DRAIN;
          tmr_nxt   = DRAIN_LD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tmr == '0) begin
          state_nxt = ST_DONE;
          latch     = 1'b1;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy  = (state == ST_SETTLE) || (state == ST_COUNT) || (state == ST_DRAIN);
  assign ro_en = busy;
  assign done  = (state == ST_DONE);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ro    (ro_a),
    .clr   (clr),
    .en    (cnt_en),
    .count (count_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ro    (ro_b),
    .clr   (clr),
    .en    (cnt_en),
    .count (count_b)
  );

  // Response is captured as DONE is entered and held until the next result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      response <= 1'b0;
    end else if (latch) begin
      response <= (count_a > count_b);
    end
  end

`ifdef RO_PUF_MARGIN_EN
  localparam logic [CNT_W:0] MARGIN_V = (CNT_W + 1)'(MARGIN);

  logic [CNT_W-1:0] diff;

  assign diff = (count_a > count_b) ? (count_a - count_b) : (count_b - count_a);

  // Reliability flag captured alongside the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      unreliable <= 1'b0;
    end else if (latch) begin
      unreliable <= ({1'b0, diff} < MARGIN_V);
    end
  end
`endif

endmodule

// File: tb/tb_ro_puf_eval.sv
// Directed testbench for ro_puf_eval (WINDOW=100, SETTLE=4, MARGIN=4) with a
// second CNT_W=4 instance sharing the same oscillator inputs.
module tb_ro_puf_eval;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start4 = 1'b0;

  int   half_a = 20;
  int   half_b = 30;
  logic gen_a = 1'b0;
  logic gen_b = 1'b0;
  logic man_a = 1'b0;
  logic man_b = 1'b0;
  logic run_a = 1'b1;
  logic run_b = 1'b1;
  logic same  = 1'b0;
  logic ro_a;
  logic ro_b;

  logic        ro_en, busy, done, response;
  logic [15:0] count_a, count_b;
  logic        ro_en4, busy4, done4, response4;
  logic [3:0]  count_a4, count_b4;
`ifdef RO_PUF_MARGIN_EN
  logic        unreliable, unreliable4;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always begin #(half_a); gen_a = ~gen_a; end
  always begin #(half_b); gen_b = ~gen_b; end

  assign ro_a = run_a ? gen_a : man_a;
  assign ro_b = same ? ro_a : (run_b ? gen_b : man_b);

  ro_puf_eval #(.CNT_W(16), .WINDOW(100), .SETTLE(4), .MARGIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .busy(busy), .done(done), .response(response),
    .count_a(count_a), .count_b(count_b)
`ifdef RO_PUF_MARGIN_EN
    , .unreliable(unreliable)
`endif
  );

  ro_puf_eval #(.CNT_W(4), .WINDOW(100), .SETTLE(4), .MARGIN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en4), .busy(busy4), .done(done4), .response(response4),
    .count_a(count_a4), .count_b(count_b4)
`ifdef RO_PUF_MARGIN_EN
    , .unreliable(unreliable4)
`endif
  );

  // Starts both instances; returns latency in cycles to the cycle where done
  // is sampled high, and busy observed mid-evaluation. Ends at done's negedge.
  task automatic run_eval(input bit hold, output int lat, output logic busy_mid);
    lat = 0;
    busy_mid = 1'b0;
    @(negedge clk);
    start = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin start = 1'b0; start4 = 1'b0; end
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 50) busy_mid = busy;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (ro_en !== 1'b0) begin n_err++; $display("FAIL reset_ro_en got %b want 0", ro_en); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (response !== 1'b0) begin n_err++; $display("FAIL reset_response got %b want 0", response); end
    n_vec++; if (count_a !== 16'd0 || count_b !== 16'd0) begin
      n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", count_a, count_b); end
`ifdef RO_PUF_MARGIN_EN
    n_vec++; if (unreliable !== 1'b0) begin n_err++; $display("FAIL reset_unreliable got %b want 0", unreliable); end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    int lat;
    logic bm;
    half_a = 20; half_b = 30; run_a = 1'b1; run_b = 1'b1; same = 1'b0;
    repeat (3) @(negedge clk);
    run_eval(1'b0, lat, bm);
    n_vec++; if (lat !== 107) begin n_err++; $display("FAIL nom_latency got %0d want 107", lat); end
    n_vec++; if (bm !== 1'b1) begin n_err++; $display("FAIL nom_busy_mid got %b want 1", bm); end
    n_vec++; if (count_a < 24 || count_a > 26) begin n_err++; $display("FAIL nom_count_a got %0d want 25+/-1", count_a); end
    n_vec++; if (count_b < 16 || count_b > 18) begin n_err++; $display("FAIL nom_count_b got %0d want 17+/-1", count_b); end
    n_vec++; if (response !== 1'b1) begin n_err++; $display("FAIL nom_response got %b want 1", response); end
    n_vec++; if (ro_en !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL nom_done_ctrl got ro_en=%b busy=%b want 0/0", ro_en, busy); end
`ifdef RO_PUF_MARGIN_EN
    n_vec++; if (unreliable !== 1'b0) begin n_err++; $display("FAIL nom_unreliable got %b want 0", unreliable); end
`endif
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL nom_done_pulse got %b want 0", done); end
    n_vec++; if (response !== 1'b1 || count_a < 24 || count_a > 26) begin
      n_err++; $display("FAIL nom_hold got resp=%b a=%0d want 1/25+/-1", response, count_a); end
  endtask

  task automatic test_swapped();
    int lat;
    logic bm;
    half_a = 30; half_b = 20;
    repeat (3) @(negedge clk);
    run_eval(1'b0, lat, bm);
    n_vec++; if (lat !== 107) begin n_err++; $display("FAIL swap_latency got %0d want 107", lat); end
    n_vec++; if (count_a < 16 || count_a > 18 || count_b < 24 || count_b > 26) begin
      n_err++; $display("FAIL swap_counts got %0d/%0d want 17/25 +/-1", count_a, count_b); end
    n_vec++; if (response !== 1'b0) begin n_err++; $display("FAIL swap_response got %b want 0", response); end
  endtask

  task automatic test_identical();
    int lat;
    logic bm;
    half_a = 20; same = 1'b1;
    repeat (3) @(negedge clk);
    run_eval(1'b0, lat, bm);
    n_vec++; if (count_a !== count_b) begin n_err++; $display("FAIL same_counts got %0d/%0d want equal", count_a, count_b); end
    n_vec++; if (response !== 1'b0) begin n_err++; $display("FAIL same_response got %b want 0", response); end
`ifdef RO_PUF_MARGIN_EN
    n_vec++; if (unreliable !== 1'b1) begin n_err++; $display("FAIL same_unreliable got %b want 1", unreliable); end
`endif
    same = 1'b0;
  endtask

  task automatic test_saturation();
    int lat;
    logic bm;
    half_a = 20; half_b = 30;
    repeat (3) @(negedge clk);
    run_eval(1'b0, lat, bm);
    n_vec++; if (done4 !== 1'b1) begin n_err++; $display("FAIL sat_done4 got %b want 1", done4); end
    n_vec++; if (count_a4 !== 4'd15) begin n_err++; $display("FAIL sat_count_a4 got %0d want 15", count_a4); end
    n_vec++; if (count_b4 !== 4'd15) begin n_err++; $display("FAIL sat_count_b4 got %0d want 15", count_b4); end
    n_vec++; if (response4 !== 1'b0) begin n_err++; $display("FAIL sat_response4 got %b want 0", response4); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int lat2;
    logic bm;
    logic idle_ok;
    half_a = 20; half_b = 30;
    repeat (3) @(negedge clk);
    run_eval(1'b1, lat, bm);
    n_vec++; if (lat !== 107) begin n_err++; $display("FAIL b2b_first_latency got %0d want 107", lat); end
    lat2 = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) begin
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap got busy=%b want 0", busy); end
      end
      if (n == 2) begin
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart got busy=%b want 1", busy); end
      end
      if (done) begin lat2 = n; break; end
    end
    n_vec++; if (lat2 !== 108) begin n_err++; $display("FAIL b2b_done_spacing got %0d want 108", lat2); end
    start = 1'b0; start4 = 1'b0;
    idle_ok = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
    end
    n_vec++; if (idle_ok !== 1'b1) begin n_err++; $display("FAIL b2b_no_queue got idle=%b want 1", idle_ok); end
  endtask

  task automatic test_ignore_busy_start();
    int lat;
    logic idle_ok;
    repeat (3) @(negedge clk);
    @(negedge clk);
    start = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; start4 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      start = (n == 40 || n == 80);
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
    n_vec++; if (lat !== 107) begin n_err++; $display("FAIL ign_latency got %0d want 107", lat); end
    idle_ok = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
    end
    n_vec++; if (idle_ok !== 1'b1) begin n_err++; $display("FAIL ign_restart got idle=%b want 1", idle_ok); end
  endtask

  task automatic test_reset_mid();
    logic done_seen;
    half_a = 20; half_b = 30;
    repeat (3) @(negedge clk);
    @(negedge clk);
    start = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; start4 = 1'b0;
    repeat (50) @(negedge clk);
    n_vec++; if (count_a === 16'd0) begin n_err++; $display("FAIL rmid_counting got count_a=%0d want >0", count_a); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_vec++; if (busy !== 1'b0 || ro_en !== 1'b0) begin
      n_err++; $display("FAIL rmid_ctrl got busy=%b ro_en=%b want 0/0", busy, ro_en); end
    n_vec++; if (count_a !== 16'd0 || count_b !== 16'd0) begin
      n_err++; $display("FAIL rmid_counts got %0d/%0d want 0/0", count_a, count_b); end
    done_seen = 1'b0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
    end
    n_vec++; if (done_seen !== 1'b0) begin n_err++; $display("FAIL rmid_no_done got activity=%b want 0", done_seen); end
  endtask

  task automatic test_masked_edges();
    int lat;
    run_a = 1'b0; run_b = 1'b0; same = 1'b0; man_a = 1'b0; man_b = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0; start4 = 1'b0;
    man_a = 1'b1; man_b = 1'b1;
    lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #2;
      if (n == 2) begin man_a = 1'b0; man_b = 1'b0; end
      if (n == 104) begin man_a = 1'b1; man_b = 1'b1; end
      if (n == 106) begin man_a = 1'b0; man_b = 1'b0; end
      @(negedge clk);
      if (done) begin lat = n + 1; break; end
    end
    n_vec++; if (lat !== 107) begin n_err++; $display("FAIL mask_latency got %0d want 107", lat); end
    n_vec++; if (count_a !== 16'd0 || count_b !== 16'd0) begin
      n_err++; $display("FAIL mask_counts got %0d/%0d want 0/0", count_a, count_b); end
    n_vec++; if (response !== 1'b0) begin n_err++; $display("FAIL mask_response got %b want 0", response); end
    run_a = 1'b1; run_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_swapped();
    test_identical();
    test_saturation();
    test_back_to_back();
    test_ignore_busy_start();
    test_reset_mid();
    test_masked_edges();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
